// File: rtl/z80_trace_pkg.sv
// Shared types for the Z80 bus tracer: 3-bit event codes and the per-tick flags that mark each qualifying bus event.
package z80_trace_pkg;

  typedef enum logic [2:0] {
    EV_FETCH       = 3'd0,
    EV_MEM_RD      = 3'd1,
    EV_MEM_WR      = 3'd2,
    EV_IO_RD       = 3'd3,
    EV_IO_WR       = 3'd4,
    EV_RST_ASSERT  = 3'd5,
    EV_RST_RELEASE = 3'd6,
    EV_HALT        = 3'd7
  } ev_type_e;

  // One bit per event class that qualified on the current tick, highest priority first.
  typedef struct packed {
    logic rst_assert;
    logic rst_release;
    logic halt;
    logic rd;
    logic wr;
  } ev_flags_t;

  function automatic logic [2:0] flag_count(input ev_flags_t f);
    flag_count = 3'(f.rst_assert) + 3'(f.rst_release) + 3'(f.halt) + 3'(f.rd) + 3'(f.wr);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Sync FIFO, first-word-fall-through head read from registered storage; head visible the cycle after the write.
// Write while full is discarded unless a pop happens in the same cycle; rd_rdy is ignored while empty.
module trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_vld,
  input  logic [W-1:0]             wr_dat,
  input  logic                     rd_rdy,
  output logic [W-1:0]             rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = ~empty & rd_rdy;
  assign do_push = wr_vld & (~full | do_pop);
  assign rd_dat  = empty ? '0 : mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/z80_bus_tracer.sv
// Classifies each CPU-clock rise into at most one bus event and queues it; out_valid rises 2 eclk after the tick.
// out_* hold while stalled; drops from priority or a full FIFO count in overflow_cnt. TRACE_TIMESTAMP_EN adds out_ts.
module z80_bus_tracer
  import z80_trace_pkg::*;
#(
  parameter int AW    = 16,
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int OVF_W = 8
`ifdef TRACE_TIMESTAMP_EN
  , parameter int TS_W = 16
`endif
) (
  input  logic                    eclk,
  input  logic                    _ereset,
  input  logic                    clk,
  input  logic                    trace_en,
  input  logic                    _m1,
  input  logic                    _rd,
  input  logic                    _wr,
  input  logic                    _mreq,
  input  logic                    _iorq,
  input  logic                    _halt,
  input  logic                    _reset,
  input  logic [AW-1:0]           ab,
  input  logic [DW-1:0]           db_i,
  input  logic [DW-1:0]           db_o,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_type,
  output logic [AW-1:0]           out_addr,
  output logic [DW-1:0]           out_data,
  output logic                    halted,
  output logic [OVF_W-1:0]        overflow_cnt,
  input  logic                    clr_ovf,
  output logic [$clog2(DEPTH):0]  level
`ifdef TRACE_TIMESTAMP_EN
  , output logic [TS_W-1:0]       out_ts
`endif
);

  typedef struct packed {
    ev_type_e      typ;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts;
`endif
  } entry_t;

  logic             clk_last, rd_last, wr_last, reset_last, halt_last;
  logic             tick, capture, pend_vld;
  logic             fifo_full, fifo_empty, pop, drop;
  ev_flags_t        flags;
  logic [2:0]       n_flags, discards, ovf_inc;
  logic [OVF_W+2:0] ovf_sum;
  logic [OVF_W-1:0] ovf_next;
  entry_t           cur, pend_entry, head;
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]  ts_cnt;
`endif

  assign tick = clk & ~clk_last;

  // A rd/wr edge only qualifies when a memory or I/O cycle is in progress.
  always_comb begin
    flags.rst_assert  = reset_last & ~_reset;
    flags.rst_release = ~reset_last & _reset;
    flags.halt        = halt_last & ~_halt;
    flags.rd          = rd_last & ~_rd & (~_mreq | ~_iorq);
    flags.wr          = wr_last & ~_wr & (~_mreq | ~_iorq);
  end

  always_comb begin
    cur      = '0;
    cur.addr = ab;
`ifdef TRACE_TIMESTAMP_EN
    cur.ts   = ts_cnt + 1'b1;
`endif
    if (flags.rst_assert) begin
      cur.typ = EV_RST_ASSERT;
    end else if (flags.rst_release) begin
      cur.typ = EV_RST_RELEASE;
    end else if (flags.halt) begin
      cur.typ = EV_HALT;
    end else if (flags.rd) begin
      cur.data = db_i;
      if (!_mreq) cur.typ = _m1 ? EV_MEM_RD : EV_FETCH;
      else        cur.typ = EV_IO_RD;
    end else if (flags.wr) begin
      cur.data = db_o;
      cur.typ  = _mreq ? EV_IO_WR : EV_MEM_WR;
    end
  end

  assign n_flags  = flag_count(flags);
  assign capture  = tick & trace_en & (n_flags != 3'd0);
  assign discards = capture ? (n_flags - 3'd1) : 3'd0;
  assign pop      = ~fifo_empty & out_ready;
  assign drop     = pend_vld & fifo_full & ~pop;
  assign ovf_inc  = discards + {2'b00, drop};
  assign ovf_sum  = {3'b000, overflow_cnt} + {{OVF_W{1'b0}}, ovf_inc};

  always_comb begin
    if (clr_ovf)                                ovf_next = '0;
    else if (ovf_sum > {3'b000, {OVF_W{1'b1}}}) ovf_next = '1;
    else                                        ovf_next = ovf_sum[OVF_W-1:0];
  end

  always_ff @(posedge eclk or negedge _ereset) begin
    if (!_ereset) begin
      clk_last     <= 1'b1;
      rd_last      <= 1'b1;
      wr_last      <= 1'b1;
      reset_last   <= 1'b1;
      halt_last    <= 1'b1;
      pend_vld     <= 1'b0;
      pend_entry   <= '0;
      halted       <= 1'b0;
      overflow_cnt <= '0;
`ifdef TRACE_TIMESTAMP_EN
      ts_cnt       <= '0;
`endif
    end else begin
      clk_last <= clk;
      // Edge history follows the bus even while tracing is off.
      if (tick) begin
        rd_last    <= _rd;
        wr_last    <= _wr;
        reset_last <= _reset;
        halt_last  <= _halt;
`ifdef TRACE_TIMESTAMP_EN
        ts_cnt     <= ts_cnt + 1'b1;
`endif
      end
      pend_vld <= capture;
      if (capture) pend_entry <= cur;
      if (capture && cur.typ == EV_HALT) halted <= 1'b1;
      overflow_cnt <= ovf_next;
    end
  end

  trace_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (eclk),
    .rst_n  (_ereset),
    .wr_vld (pend_vld),
    .wr_dat (pend_entry),
    .rd_rdy (out_ready),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level)
  );

  assign out_valid = ~fifo_empty;
  assign out_type  = head.typ;
  assign out_addr  = head.addr;
  assign out_data  = head.data;
`ifdef TRACE_TIMESTAMP_EN
  assign out_ts    = head.ts;
`endif

endmodule

// File: tb/tb_z80_bus_tracer.sv
// Bench for z80_bus_tracer: event-list model of the bus rules plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_z80_bus_tracer;

  localparam int DEPTH   = 16;
  localparam int OVF_MAX = 255;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TB_TS_W = 4;
`endif

  logic eclk = 1'b0, ereset_n = 1'b0, clk = 1'b1, trace_en = 1'b1;
  logic m1_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
  logic halt_n = 1'b1, reset_n = 1'b1;
  logic [15:0] ab = '0;
  logic [7:0]  db_i = '0, db_o = '0;
  logic        out_ready = 1'b0, clr_ovf = 1'b0;
  logic        out_valid, halted;
  logic [2:0]  out_type;
  logic [15:0] out_addr;
  logic [7:0]  out_data, overflow_cnt;
  logic [4:0]  level;
`ifdef TRACE_TIMESTAMP_EN
  logic [TB_TS_W-1:0] out_ts;
`endif

  always #5 eclk = ~eclk;

  z80_bus_tracer #(
    .AW(16), .DW(8), .DEPTH(DEPTH), .OVF_W(8)
`ifdef TRACE_TIMESTAMP_EN
    , .TS_W(TB_TS_W)
`endif
  ) dut (
    .eclk(eclk), ._ereset(ereset_n), .clk(clk), .trace_en(trace_en),
    ._m1(m1_n), ._rd(rd_n), ._wr(wr_n), ._mreq(mreq_n), ._iorq(iorq_n),
    ._halt(halt_n), ._reset(reset_n), .ab(ab), .db_i(db_i), .db_o(db_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_addr(out_addr), .out_data(out_data), .halted(halted),
    .overflow_cnt(overflow_cnt), .clr_ovf(clr_ovf), .level(level)
`ifdef TRACE_TIMESTAMP_EN
    , .out_ts(out_ts)
`endif
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Model: a trace is a queue of entries; each CPU-clock rise yields a list of
  // qualifying events in priority order, the first is kept and the rest are lost.
  typedef struct { int t; int a; int d; int ts; } ent_t;
  ent_t q[$];
  ent_t evs[$];
  ent_t pend_e;
  bit   m_pend, m_halted, m_pop, m_full;
  bit   p_clk, p_rd, p_wr, p_rst, p_halt;
  int   m_ovf, m_ticks, inc;

  function automatic ent_t mk(input int t, input int a, input int d);
    ent_t r;
    r.t = t; r.a = a; r.d = d;
`ifdef TRACE_TIMESTAMP_EN
    r.ts = m_ticks % (1 << TB_TS_W);
`else
    r.ts = 0;
`endif
    return r;
  endfunction

  always @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      q.delete();
      m_pend = 0; m_halted = 0; m_ovf = 0; m_ticks = 0;
      p_clk = 1; p_rd = 1; p_wr = 1; p_rst = 1; p_halt = 1;
    end else begin
      inc    = 0;
      m_full = (q.size() == DEPTH);
      m_pop  = (q.size() > 0) && out_ready;
      if (m_pop) void'(q.pop_front());
      if (m_pend) begin
        if (m_full && !m_pop) inc++;
        else q.push_back(pend_e);
      end
      m_pend = 0;
      if (!p_clk && clk) begin
        m_ticks++;
        evs.delete();
        if (p_rst && !reset_n)  evs.push_back(mk(5, ab, 0));
        if (!p_rst && reset_n)  evs.push_back(mk(6, ab, 0));
        if (p_halt && !halt_n)  evs.push_back(mk(7, ab, 0));
        if (p_rd && !rd_n) begin
          if (!mreq_n)      evs.push_back(mk(m1_n ? 1 : 0, ab, db_i));
          else if (!iorq_n) evs.push_back(mk(3, ab, db_i));
        end
        if (p_wr && !wr_n) begin
          if (!mreq_n)      evs.push_back(mk(2, ab, db_o));
          else if (!iorq_n) evs.push_back(mk(4, ab, db_o));
        end
        if (trace_en && evs.size() > 0) begin
          pend_e = evs[0];
          m_pend = 1;
          inc += evs.size() - 1;
          if (evs[0].t == 7) m_halted = 1;
        end
        p_rd = rd_n; p_wr = wr_n; p_rst = reset_n; p_halt = halt_n;
      end
      p_clk = clk;
      if (clr_ovf) m_ovf = 0;
      else         m_ovf = (m_ovf + inc > OVF_MAX) ? OVF_MAX : m_ovf + inc;
    end
  end

  always @(negedge eclk) begin
    if (ereset_n) begin
      chk("m_valid", out_valid, q.size() > 0);
      chk("m_level", level, q.size());
      chk("m_ovf", overflow_cnt, m_ovf);
      chk("m_halted", halted, m_halted);
      if (q.size() > 0) begin
        chk("m_type", out_type, q[0].t);
        chk("m_addr", out_addr, q[0].a);
        chk("m_data", out_data, q[0].d);
`ifdef TRACE_TIMESTAMP_EN
        chk("m_ts", out_ts, q[0].ts);
`endif
      end
    end
  end

  // One CPU clock period; returns just after the eclk edge that sees the rise.
  task automatic cyc(input logic m1, rd, wr, mreq, iorq,
                     input logic [15:0] a, input logic [7:0] di, input logic [7:0] dox);
    @(posedge eclk); #1;
    clk = 1'b0; m1_n = m1; rd_n = rd; wr_n = wr; mreq_n = mreq; iorq_n = iorq;
    ab = a; db_i = di; db_o = dox;
    @(posedge eclk); #1;
    clk = 1'b1;
    @(posedge eclk);
    @(negedge eclk);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, 8'h00);
  endtask

  task automatic fetch(input logic [15:0] a, input logic [7:0] d);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, a, d, 8'h00);
    idle();
  endtask

  task automatic pop_one();
    @(posedge eclk); #1 out_ready = 1'b1;
    @(posedge eclk); #1 out_ready = 1'b0;
    @(negedge eclk);
  endtask

  initial begin
    repeat (3) @(posedge eclk);
    @(negedge eclk);
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_type", out_type, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_data", out_data, 0);
    @(posedge eclk); #1 ereset_n = 1'b1;
    idle();

    // Opcode fetch and its latency
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 8'h3E, 8'h00);
    chk("fetch_lat1", out_valid, 0);
    @(negedge eclk);
    chk("fetch_lat2", out_valid, 1);
    chk("fetch_type", out_type, 0);
    chk("fetch_addr", out_addr, 16'h0000);
    chk("fetch_data", out_data, 8'h3E);
    idle();
    pop_one();

    // Memory write then I/O read
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h8001, 8'h00, 8'hA5);
    idle();
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00FE, 8'h12, 8'h00);
    idle();
    chk("mw_level", level, 2);
    chk("mw_type", out_type, 2);
    chk("mw_addr", out_addr, 16'h8001);
    chk("mw_data", out_data, 8'hA5);
    pop_one();
    chk("ior_type", out_type, 3);
    chk("ior_addr", out_addr, 16'h00FE);
    chk("ior_data", out_data, 8'h12);
    pop_one();
    chk("ior_drained", level, 0);

    // Fill past capacity, clear the counter, drain in order
    for (int i = 0; i < DEPTH + 3; i++) fetch(16'(i), 8'(8'h40 + i));
    chk("fill_level", level, DEPTH);
    chk("fill_ovf", overflow_cnt, 3);
    @(posedge eclk); #1 clr_ovf = 1'b1;
    @(posedge eclk); #1 clr_ovf = 1'b0;
    @(negedge eclk);
    chk("clr_ovf", overflow_cnt, 0);
    @(posedge eclk); #1 out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge eclk);
      chk("drain_addr", out_addr, i);
      chk("drain_data", out_data, 32'h40 + i);
    end
    @(negedge eclk);
    chk("drain_empty", out_valid, 0);
    @(posedge eclk); #1 out_ready = 1'b0;

    // Push and pop together while full: nothing dropped
    for (int i = 0; i < DEPTH; i++) fetch(16'h0200 + 16'(i), 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0300, 8'h77, 8'h00);
    out_ready = 1'b1;
    @(posedge eclk); #1 out_ready = 1'b0;
    @(negedge eclk);
    chk("fullpp_level", level, DEPTH);
    chk("fullpp_ovf", overflow_cnt, 0);
    chk("fullpp_head", out_addr, 16'h0201);
    idle();
    @(posedge eclk); #1 out_ready = 1'b1;
    repeat (DEPTH + 2) @(posedge eclk);
    #1 out_ready = 1'b0;
    @(negedge eclk);
    chk("fullpp_drained", level, 0);

    // Reset edge and read edge on the same tick, then halt
    reset_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 8'h99, 8'h00);
    @(negedge eclk);
    chk("rsta_level", level, 1);
    chk("rsta_type", out_type, 5);
    chk("rsta_addr", out_addr, 16'h1234);
    chk("rsta_data", out_data, 0);
    chk("rsta_ovf", overflow_cnt, 1);
    idle();
    pop_one();
    halt_n = 1'b0;
    idle();
    @(negedge eclk);
    chk("halt_type", out_type, 7);
    chk("halt_set", halted, 1);
    pop_one();
    halt_n = 1'b1;
    idle();
    idle();
    chk("halt_sticky", halted, 1);
    reset_n = 1'b1;
    idle();
    @(negedge eclk);
    chk("rstr_type", out_type, 6);
    pop_one();

    // Tracing disabled across a write edge
    trace_en = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4444, 8'h00, 8'h55);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4444, 8'h00, 8'h55);
    trace_en = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4444, 8'h00, 8'h55);
    idle();
    chk("dis_level", level, 0);
    chk("dis_valid", out_valid, 0);

    // Async reset with entries queued
    for (int i = 0; i < 5; i++) fetch(16'h0500 + 16'(i), 8'(i));
    chk("pre_arst_level", level, 5);
    @(posedge eclk); #2 ereset_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_halted", halted, 0);
    chk("arst_ovf", overflow_cnt, 0);
    @(posedge eclk); #1 ereset_n = 1'b1;

`ifdef TRACE_TIMESTAMP_EN
    idle();
    idle();
    fetch(16'h0600, 8'h01);
    repeat (5) idle();
    fetch(16'h0601, 8'h02);
    repeat (4) idle();
    fetch(16'h0602, 8'h03);
    chk("ts_3", out_ts, 3);
    pop_one();
    chk("ts_10", out_ts, 10);
    pop_one();
    chk("ts_wrap", out_ts, 0);
    pop_one();
`endif

    repeat (4) @(negedge eclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
